// File: rtl/mem_access_unit.sv
// Memory stage: drives a byte-enabled synchronous data RAM from the M register,
// splits misaligned half/word accesses over two cycles and holds the W register.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WIDTH  = 12,
  parameter int RF_WIDTH   = 5,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  regWriteM,
  input  logic [1:0]            resultSelM,
  input  logic                  memWriteM,
  input  logic [2:0]            memCtrlM,
  input  logic [DATA_WIDTH-1:0] aluResultM,
  input  logic [DATA_WIDTH-1:0] memDinM,
  input  logic [RF_WIDTH-1:0]   regAddr3M,
  input  logic [ROM_WIDTH-1:0]  pcM,
  input  logic [DATA_WIDTH-1:0] immExtM,
  output logic                  stallM,
  output logic                  ramEn,
  output logic                  ramWe,
  output logic [3:0]            ramBe,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramWdata,
  input  logic [DATA_WIDTH-1:0] ramRdata,
  output logic                  regWriteW,
  output logic [1:0]            resultSelW,
  output logic [DATA_WIDTH-1:0] aluResultW,
  output logic [DATA_WIDTH-1:0] readDataW,
  output logic [RF_WIDTH-1:0]   regAddr3W,
  output logic [ROM_WIDTH-1:0]  pcW,
  output logic [DATA_WIDTH-1:0] immExtW
);

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  state_t state;

  logic                    is_load;
  logic                    active;
  logic [1:0]              off;
  logic [1:0]              width;
  logic                    misaligned;
  logic                    split_req;
  logic                    w_load;
  logic [3:0]              base_mask;
  logic [7:0]              mask8;
  logic [2*DATA_WIDTH-1:0] wdata64;
  logic [ADDR_WIDTH-1:0]   word_addr;

  logic [DATA_WIDTH-1:0]   low_buf;
  logic [1:0]              off_w;
  logic [1:0]              width_w;
  logic                    unsigned_w;
  logic                    split_w;

  logic [2*DATA_WIDTH-1:0] assembled;
  logic [2*DATA_WIDTH-1:0] shifted;
  logic                    unused_bits;

  // ---------------------------------------------------------------------------
  // Request decode and byte-lane mapping
  // ---------------------------------------------------------------------------
  assign is_load    = (resultSelM == 2'b01);
  assign active     = is_load | memWriteM;
  assign off        = aluResultM[1:0];
  assign width      = memCtrlM[1:0];
  assign misaligned = ((width == 2'b01) && (off == 2'b11)) ||
                      (width[1] && (off != 2'b00));
  assign split_req  = active && misaligned;
  assign word_addr  = aluResultM[ADDR_WIDTH+1:2];

  always_comb begin
    unique case (width)
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  assign mask8   = {4'b0000, base_mask} << off;
  assign wdata64 = {{DATA_WIDTH{1'b0}}, memDinM} << {off, 3'b000};

  // ---------------------------------------------------------------------------
  // RAM port and stall, combinational from state and the M register
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned and infers a latch.
    ramEn    = 1'b0;
    ramWe    = 1'b0;
    ramBe    = 4'b0000;
    ramAddr  = word_addr;
    ramWdata = wdata64[DATA_WIDTH-1:0];
    stallM   = 1'b0;
    unique case (state)
      IDLE: begin
        if (active) begin
          ramEn  = 1'b1;
          ramWe  = memWriteM;
          ramBe  = mask8[3:0];
          stallM = misaligned;
        end
      end
      SPLIT: begin
        // Execute is stalled, so the M inputs still describe the same access.
        ramAddr  = word_addr + ADDR_WIDTH'(1);
        ramWdata = wdata64[2*DATA_WIDTH-1:DATA_WIDTH];
        if (active && (mask8[7:4] != 4'b0000)) begin
          ramEn = 1'b1;
          ramWe = memWriteM;
          ramBe = mask8[7:4];
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State machine and W register
  // ---------------------------------------------------------------------------
  // The first cycle of a split puts a bubble in W; every other cycle loads M.
  assign w_load = (state == SPLIT) || !split_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      low_buf    <= '0;
      off_w      <= 2'b00;
      width_w    <= 2'b00;
      unsigned_w <= 1'b0;
      split_w    <= 1'b0;
      regWriteW  <= 1'b0;
      resultSelW <= 2'b00;
      aluResultW <= '0;
      regAddr3W  <= '0;
      pcW        <= '0;
      immExtW    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples its inputs from before the edge, independent of statement order.
      state <= (state == IDLE && split_req) ? SPLIT : IDLE;

      if (state == SPLIT && is_load) begin
        low_buf <= ramRdata;
      end

      if (w_load) begin
        regWriteW  <= regWriteM;
        resultSelW <= resultSelM;
        aluResultW <= aluResultM;
        regAddr3W  <= regAddr3M;
        pcW        <= pcM;
        immExtW    <= immExtM;
        off_w      <= off;
        width_w    <= width;
        unsigned_w <= memCtrlM[2];
        split_w    <= (state == SPLIT);
      end else begin
        regWriteW  <= 1'b0;
        resultSelW <= 2'b00;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting: align, select width, extend
  // ---------------------------------------------------------------------------
  assign assembled = split_w ? {ramRdata, low_buf} : {{DATA_WIDTH{1'b0}}, ramRdata};
  assign shifted   = assembled >> {off_w, 3'b000};

  always_comb begin
    unique case (width_w)
      2'b00:   readDataW = {{(DATA_WIDTH-8){~unsigned_w & shifted[7]}}, shifted[7:0]};
      2'b01:   readDataW = {{(DATA_WIDTH-16){~unsigned_w & shifted[15]}}, shifted[15:0]};
      default: readDataW = shifted[DATA_WIDTH-1:0];
    endcase
  end

  // Address bits above the RAM range and the discarded top half of the shift.
  assign unused_bits = ^{aluResultM[DATA_WIDTH-1:ADDR_WIDTH+2],
                         shifted[2*DATA_WIDTH-1:DATA_WIDTH]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed reference memory, writeback
// scoreboard drained by a monitor, and a behavioural RAM on the DUT port.
module tb_mem_access_unit;

  localparam int DW     = 32;
  localparam int RW     = 12;
  localparam int FW     = 5;
  localparam int AW     = 10;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = 4 * NWORDS;

  logic          clk;
  logic          rstn;
  logic          regWriteM;
  logic [1:0]    resultSelM;
  logic          memWriteM;
  logic [2:0]    memCtrlM;
  logic [DW-1:0] aluResultM;
  logic [DW-1:0] memDinM;
  logic [FW-1:0] regAddr3M;
  logic [RW-1:0] pcM;
  logic [DW-1:0] immExtM;
  logic          stallM;
  logic          ramEn;
  logic          ramWe;
  logic [3:0]    ramBe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramWdata;
  logic [DW-1:0] ramRdata;
  logic          regWriteW;
  logic [1:0]    resultSelW;
  logic [DW-1:0] aluResultW;
  logic [DW-1:0] readDataW;
  logic [FW-1:0] regAddr3W;
  logic [RW-1:0] pcW;
  logic [DW-1:0] immExtW;

  mem_access_unit #(
    .DATA_WIDTH(DW), .ROM_WIDTH(RW), .RF_WIDTH(FW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .regWriteM(regWriteM), .resultSelM(resultSelM), .memWriteM(memWriteM),
    .memCtrlM(memCtrlM), .aluResultM(aluResultM), .memDinM(memDinM),
    .regAddr3M(regAddr3M), .pcM(pcM), .immExtM(immExtM),
    .stallM(stallM), .ramEn(ramEn), .ramWe(ramWe), .ramBe(ramBe),
    .ramAddr(ramAddr), .ramWdata(ramWdata), .ramRdata(ramRdata),
    .regWriteW(regWriteW), .resultSelW(resultSelW), .aluResultW(aluResultW),
    .readDataW(readDataW), .regAddr3W(regAddr3W), .pcW(pcW), .immExtW(immExtW)
  );

  typedef struct {
    logic [1:0]    rsel;
    logic [FW-1:0] rd;
    logic [DW-1:0] alu;
    logic [RW-1:0] pc;
    logic [DW-1:0] imm;
    logic [DW-1:0] rdata;
  } wb_t;

  wb_t        sb[$];
  wb_t        mon_e;
  int         total = 0;
  int         bad   = 0;
  logic [DW-1:0] ram [0:NWORDS-1];
  logic [7:0]    model_mem [0:NBYTES-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous read-first RAM with byte enables.
  always @(posedge clk) begin
    if (ramEn) begin
      ramRdata <= ram[ramAddr];
      if (ramWe) begin
        check("ram_write_be_nonzero", 32'(ramBe != 4'b0000), 32'd1);
        for (int i = 0; i < 4; i++)
          if (ramBe[i]) ram[ramAddr][8*i +: 8] <= ramWdata[8*i +: 8];
      end
    end
  end

  // Writeback monitor: every W-stage register write must match the next expectation.
  always @(negedge clk) begin
    if (rstn && regWriteW) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: rd=%0d alu=0x%08h with empty scoreboard", regAddr3W, aluResultW);
      end else begin
        mon_e = sb.pop_front();
        check("wb_resultSel", 32'(resultSelW), 32'(mon_e.rsel));
        check("wb_regAddr3", 32'(regAddr3W), 32'(mon_e.rd));
        check("wb_aluResult", aluResultW, mon_e.alu);
        check("wb_pc", 32'(pcW), 32'(mon_e.pc));
        check("wb_immExt", immExtW, mon_e.imm);
        if (mon_e.rsel == 2'b01) check("wb_readData", readDataW, mon_e.rdata);
      end
    end
  end

  // Reference memory: little-endian bytes, byte address wraps at the RAM size.
  function automatic logic [31:0] model_load(input logic [AW+1:0] baddr, input int n, input logic uns);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[(int'(baddr) + i) % NBYTES];
    if (!uns && n < 4 && v[8*n-1])
      for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic model_store(input logic [AW+1:0] baddr, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) model_mem[(int'(baddr) + i) % NBYTES] = d[8*i +: 8];
  endtask

  task automatic poke(input int w, input logic [31:0] val);
    ram[w] = val;
    for (int i = 0; i < 4; i++) model_mem[4*w + i] = val[8*i +: 8];
  endtask

  task automatic drive_nop();
    regWriteM  = 1'b0;
    resultSelM = 2'b00;
    memWriteM  = 1'b0;
    memCtrlM   = 3'b000;
    aluResultM = '0;
    memDinM    = '0;
    regAddr3M  = '0;
    pcM        = '0;
    immExtM    = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the access.
  task automatic issue(input logic rw, input logic [1:0] rsel, input logic mw,
                       input logic [2:0] ctrl, input logic [31:0] alu, input logic [31:0] din,
                       input logic [FW-1:0] rd, input logic [RW-1:0] pc, input logic [31:0] imm);
    int            n;
    int            off;
    int            b;
    logic          act;
    logic          spl;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [3:0]    lo;
    logic [3:0]    hi;
    wb_t           e;
    regWriteM  = rw;
    resultSelM = rsel;
    memWriteM  = mw;
    memCtrlM   = ctrl;
    aluResultM = alu;
    memDinM    = din;
    regAddr3M  = rd;
    pcM        = pc;
    immExtM    = imm;
    n   = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    off = int'(alu[1:0]);
    act = (rsel == 2'b01) || mw;
    spl = act && (off + n > 4);
    a0  = alu[AW+1:2];
    a1  = a0 + AW'(1);
    lo  = 4'b0000;
    hi  = 4'b0000;
    for (int i = 0; i < n; i++) begin
      b = off + i;
      if (b < 4) lo[b] = 1'b1;
      else       hi[b-4] = 1'b1;
    end
    if (rw) begin
      e.rsel  = rsel;
      e.rd    = rd;
      e.alu   = alu;
      e.pc    = pc;
      e.imm   = imm;
      e.rdata = model_load(alu[AW+1:0], n, ctrl[2]);
      sb.push_back(e);
    end
    if (mw) model_store(alu[AW+1:0], n, din);

    @(negedge clk);
    check("stallM_first", 32'(stallM), 32'(spl));
    check("ramEn_first", 32'(ramEn), 32'(act));
    check("ramWe_first", 32'(ramWe), 32'(act && mw));
    check("ramBe_first", 32'(ramBe), act ? 32'(lo) : 32'd0);
    if (act) check("ramAddr_first", 32'(ramAddr), 32'(a0));
    if (mw)
      for (int i = 0; i < n; i++) begin
        b = off + i;
        if (b < 4) check("ramWdata_first", 32'(ramWdata[8*b +: 8]), 32'(din[8*i +: 8]));
      end
    @(posedge clk);

    if (spl) begin
      @(negedge clk);
      check("stallM_split", 32'(stallM), 32'd0);
      check("bubble_regWriteW", 32'(regWriteW), 32'd0);
      check("bubble_resultSelW", 32'(resultSelW), 32'd0);
      check("ramAddr_split", 32'(ramAddr), 32'(a1));
      check("ramBe_split", 32'(ramBe), 32'(hi));
      check("ramEn_split", 32'(ramEn), 32'(hi != 4'b0000));
      check("ramWe_split", 32'(ramWe), 32'(mw && hi != 4'b0000));
      if (mw)
        for (int i = 0; i < n; i++) begin
          b = off + i;
          if (b >= 4) check("ramWdata_split", 32'(ramWdata[8*(b-4) +: 8]), 32'(din[8*i +: 8]));
        end
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    logic [31:0] alu;
    logic [2:0]  ctrl;
    logic [1:0]  rsel;
    int          kind;

    drive_nop();
    ramRdata = '0;
    rstn = 1'b0;
    for (int w = 0; w < NWORDS; w++) poke(w, $urandom);

    #3;
    check("rst_stallM", 32'(stallM), 32'd0);
    check("rst_ramEn", 32'(ramEn), 32'd0);
    check("rst_regWriteW", 32'(regWriteW), 32'd0);
    check("rst_aluResultW", aluResultW, 32'd0);
    check("rst_pcW", 32'(pcW), 32'd0);
    #9 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Aligned word load.
    poke('h10, 32'hDEADBEEF);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'h0, 5'd1, 12'h100, 32'h11);
    // Signed byte and unsigned byte.
    poke('h10, 32'h80FF7F01);
    issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h43, 32'h0, 5'd2, 12'h104, 32'h22);
    issue(1'b1, 2'b01, 1'b0, 3'b100, 32'h42, 32'h0, 5'd3, 12'h108, 32'h33);
    // Misaligned word load spanning two words.
    poke('h10, 32'h44332211);
    poke('h11, 32'h88776655);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h41, 32'h0, 5'd4, 12'h10C, 32'h44);
    // Misaligned halfword store, then read it back unsigned.
    issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h43, 32'h0000BEEF, 5'd0, 12'h110, 32'h55);
    issue(1'b1, 2'b01, 1'b0, 3'b101, 32'h43, 32'h0, 5'd5, 12'h114, 32'h66);
    // Misaligned word load at the top word address wraps to word 0.
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0FFE, 32'h0, 5'd6, 12'h118, 32'h77);
    // Non-memory writeback.
    issue(1'b1, 2'b10, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd7, 12'h11C, 32'h88);

    // Reset pulsed while the second access of a split load is pending.
    regWriteM  = 1'b1;
    resultSelM = 2'b01;
    memWriteM  = 1'b0;
    memCtrlM   = 3'b010;
    aluResultM = 32'h81;
    regAddr3M  = 5'd9;
    @(negedge clk);
    check("pre_rst_stallM", 32'(stallM), 32'd1);
    @(posedge clk);
    #1;
    check("pre_rst_split_addr", 32'(ramAddr), 32'h21);
    #2 rstn = 1'b0;
    drive_nop();
    #1;
    check("rst_split_stallM", 32'(stallM), 32'd0);
    check("rst_split_regWriteW", 32'(regWriteW), 32'd0);
    check("rst_split_resultSelW", 32'(resultSelW), 32'd0);
    check("rst_split_aluResultW", aluResultW, 32'd0);
    check("rst_split_regAddr3W", 32'(regAddr3W), 32'd0);
    check("rst_split_pcW", 32'(pcW), 32'd0);
    check("rst_split_immExtW", immExtW, 32'd0);
    resultSelM = 2'b01;
    memCtrlM   = 3'b010;
    aluResultM = 32'h81;
    #1;
    check("rst_idle_addr", 32'(ramAddr), 32'h20);
    check("rst_idle_stallM", 32'(stallM), 32'd1);
    drive_nop();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 2'b00, 1'b1, 3'b010, 32'h84, 32'hCAFE_F00D, 5'd0, 12'h200, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h84, 32'h0, 5'd10, 12'h204, 32'h0);

    // Randomised mix of loads, stores, ALU results and bubbles.
    for (int k = 0; k < 400; k++) begin
      kind = $urandom_range(0, 9);
      alu  = $urandom;
      ctrl = 3'($urandom_range(0, 7));
      if (kind <= 3)
        issue(1'b1, 2'b01, 1'b0, ctrl, alu, 32'h0, 5'($urandom_range(1, 31)),
              12'($urandom), $urandom);
      else if (kind <= 6)
        issue(1'b0, 2'b00, 1'b1, ctrl, alu, $urandom, 5'd0, 12'($urandom), $urandom);
      else if (kind <= 8) begin
        rsel = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        issue(1'b1, rsel, 1'b0, ctrl, alu, 32'h0, 5'($urandom_range(1, 31)),
              12'($urandom), $urandom);
      end else
        issue(1'b0, 2'b00, 1'b0, ctrl, alu, 32'h0, 5'd0, 12'($urandom), $urandom);
    end

    drive_nop();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    for (int w = 0; w < NWORDS; w++)
      check("final_mem_word", ram[w],
            {model_mem[4*w+3], model_mem[4*w+2], model_mem[4*w+1], model_mem[4*w]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
